// File: rtl/mem_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_pkg
// Shared definitions for the M-stage memory access sequencer: load/store op
// encodings, bus size codes, FSM state encoding and small op-decode helpers.
// Optional feature macro used by the top: MEM_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package mem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic mem_size_e op_size(input mem_op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
            default:              return SIZE_WORD;
        endcase
    endfunction

    function automatic logic op_is_store(input mem_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Replicate store data across all lanes so the slave can pick any lane
    // using size and the low address bits.
    function automatic logic [31:0] store_lanes(input mem_op_e op, input logic [31:0] wd);
        case (op)
            OP_SB:   return {4{wd[7:0]}};
            OP_SH:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// ---------------------------------------------------------------------------
// mem_load_ext
// Combinational load result formatting: byte/half lane select from the raw
// bus word followed by sign or zero extension. Reusable by forwarding logic.
// Ports:
//   op      in  3   load op (LB/LBU/LH/LHU/LW; store codes pass the word)
//   addr_lo in  2   low address bits of the access
//   word    in  32  raw read word from the bus
//   result  out 32  extended load result
// ---------------------------------------------------------------------------
module mem_load_ext
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        case (mem_op_e'(op))
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result = {24'b0, byte_sel};
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result = {16'b0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Memory-stage load/store sequencer. Checks alignment of the M-stage op,
// issues one SRAM-like bus transaction (req / addr_ok / data_ok), stalls the
// pipeline while it is outstanding and returns the extended load result with
// a one-cycle done pulse. Misaligned ops never reach the bus.
// Optional feature: define MEM_TIMEOUT_EN to enable a REQ+WAIT watchdog that
// aborts after TIMEOUT_CYCLES with a bus_err pulse; otherwise bus_err = 0.
// Ports:
//   clk, rst (async, active high)
//   mem_valid, mem_op[2:0], addr[31:0], wdata[31:0], flush  : M-stage inputs
//   data_req, data_wr, data_size[1:0], data_addr, data_wdata: bus request
//   data_addr_ok, data_data_ok, data_rdata                  : bus response
//   rdata, stall, done                                      : pipeline side
//   laddr_err, saddr_err, bus_err                           : exceptions
// ---------------------------------------------------------------------------
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        laddr_err,
    output logic        saddr_err,
    output logic        bus_err
);

    state_e      state_q, state_d;
    mem_op_e     op_q, op_d;
    mem_size_e   size_q, size_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        discard_q, discard_d;

    mem_op_e     op_in;
    logic        misaligned;
    logic        issue;
    logic        complete;
    logic [31:0] load_result;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
`endif

    assign op_in = mem_op_e'(mem_op);

    always_comb begin
        laddr_err = 1'b0;
        saddr_err = 1'b0;
        if (mem_valid) begin
            case (op_in)
                OP_LH, OP_LHU: laddr_err = addr[0];
                OP_LW:         laddr_err = |addr[1:0];
                OP_SH:         saddr_err = addr[0];
                OP_SW:         saddr_err = |addr[1:0];
                default:       ;
            endcase
        end
    end

    assign misaligned = laddr_err | saddr_err;
    assign issue      = (state_q == ST_IDLE) && mem_valid && !misaligned && !flush;
    // The response phase ends on data_ok; in REQ it only counts together with addr_ok.
    assign complete   = ((state_q == ST_REQ) && data_addr_ok && data_data_ok) ||
                        ((state_q == ST_WAIT) && data_data_ok);

    mem_load_ext u_load_ext (
        .op      (op_q),
        .addr_lo (addr_q[1:0]),
        .word    (data_rdata),
        .result  (load_result)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        size_d    = size_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        discard_d = discard_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = cnt_q;
        bus_err_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d   = ST_REQ;
                    op_d      = op_in;
                    size_d    = op_size(op_in);
                    wr_d      = op_is_store(op_in);
                    addr_d    = addr;
                    wdata_d   = store_lanes(op_in, wdata);
                    discard_d = 1'b0;
                end
            end
            ST_REQ, ST_WAIT: begin
                // A flushed transaction still runs to completion on the bus;
                // its result is simply dropped.
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (complete) begin
                    if (discard_q || flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                        if (!wr_q) begin
                            rdata_d = load_result;
                        end
                    end
                end else if (state_q == ST_REQ && data_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef MEM_TIMEOUT_EN
        if (issue) begin
            cnt_d = '0;
        end else if ((state_q == ST_REQ || state_q == ST_WAIT) && !complete) begin
            if (cnt_q == CNT_LAST) begin
                state_d   = ST_IDLE;
                bus_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_LB;
            size_q    <= SIZE_BYTE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            discard_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            size_q    <= size_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            discard_q <= discard_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
`endif
        end
    end

    assign data_req   = (state_q == ST_REQ);
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign rdata      = rdata_q;
    assign done       = (state_q == ST_DONE);
    assign stall      = issue || (state_q == ST_REQ) || (state_q == ST_WAIT);

`ifdef MEM_TIMEOUT_EN
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl. The stimulus process drives M-stage ops
// and a scripted bus slave and sets the cycle-level expectations; a single
// compare process checks every output each negedge against a reference model
// built from plain arithmetic (lane shifts, masks, multiplication-based
// replication, modulo alignment). A few literal values pin the model.
// Optional: MEM_TIMEOUT_EN adds the watchdog scenario (TIMEOUT_CYCLES = 8).
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3,
                           LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic        clk, rst;
    logic        mem_valid, flush;
    logic [2:0]  mem_op;
    logic [31:0] addr, wdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] rdata;
    logic        stall, done, laddr_err, saddr_err, bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Cycle-level expectations set by the stimulus process.
    logic        exp_stall, exp_req, exp_done, exp_bus_err, exp_wr;
    logic [1:0]  exp_size;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;

    // Last request seen on the bus, for literal checks after a transaction.
    logic [31:0] snap_wdata;
    logic [1:0]  snap_size;
    logic        snap_wr;
    logic        saw_req;

    mem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid    (mem_valid),
        .mem_op       (mem_op),
        .addr         (addr),
        .wdata        (wdata),
        .flush        (flush),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .rdata        (rdata),
        .stall        (stall),
        .done         (done),
        .laddr_err    (laddr_err),
        .saddr_err    (saddr_err),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] size_code(input logic [2:0] op);
        return (nbytes(op) == 1) ? 2'd0 : (nbytes(op) == 2) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic is_store(input logic [2:0] op);
        return op >= SB;
    endfunction

    function automatic logic [31:0] rep(input logic [2:0] op, input logic [31:0] wd);
        if (nbytes(op) == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (nbytes(op) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ext(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
        int          n;
        logic [31:0] mask, v;
        n = nbytes(op);
        if (n == 4) return w;
        mask = (n == 1) ? 32'hFF : 32'hFFFF;
        v    = (w >> (8 * int'(a[1:0]))) & mask;
        if ((op == LB || op == LH) && ((v & ~(mask >> 1)) != 0)) v = v | ~mask;
        return v;
    endfunction

    // {saddr_err, laddr_err}
    function automatic logic [1:0] err_model(input logic mv, input logic [2:0] op, input logic [31:0] a);
        logic mis;
        if (!mv) return 2'b00;
        mis = (int'(a[1:0]) % nbytes(op)) != 0;
        return {is_store(op) && mis, !is_store(op) && mis};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [1:0] e;
        e = err_model(mem_valid, mem_op, addr);
        chk("stall",     stall,     exp_stall);
        chk("data_req",  data_req,  exp_req);
        chk("done",      done,      exp_done);
        chk("rdata",     rdata,     exp_rdata);
        chk("laddr_err", laddr_err, e[0]);
        chk("saddr_err", saddr_err, e[1]);
        chk("bus_err",   bus_err,   exp_bus_err);
        if (exp_req) begin
            chk("data_wr",    data_wr,    exp_wr);
            chk("data_size",  data_size,  exp_size);
            chk("data_addr",  data_addr,  exp_addr);
            chk("data_wdata", data_wdata, exp_wdata);
        end
        if (data_req) begin
            saw_req    = 1'b1;
            snap_wdata = data_wdata;
            snap_size  = data_size;
            snap_wr    = data_wr;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        exp_stall   = 1'b0;
        exp_req     = 1'b0;
        exp_done    = 1'b0;
        exp_bus_err = 1'b0;
    endtask

    // addr_lat: extra REQ cycles before addr_ok; data_lat: WAIT cycles after
    // the addr_ok cycle (0 = data_ok together with addr_ok); flush_at: WAIT
    // cycle index carrying flush, -1 for none.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int addr_lat, input int data_lat,
                          input int flush_at);
        logic flushed;
        flushed = 1'b0;
        step();
        mem_valid = 1'b1; mem_op = op; addr = a; wdata = wd; flush = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = ~rd;
        idle_exp();
        exp_stall = 1'b1;
        exp_wr = is_store(op); exp_size = size_code(op); exp_addr = a; exp_wdata = rep(op, wd);
        for (int i = 0; i <= addr_lat; i++) begin
            step();
            exp_req = 1'b1; exp_stall = 1'b1;
            data_addr_ok = (i == addr_lat);
            data_data_ok = (i == addr_lat) && (data_lat == 0);
            data_rdata   = data_data_ok ? rd : ~rd;
        end
        for (int i = 1; i <= data_lat; i++) begin
            step();
            exp_req = 1'b0; exp_stall = 1'b1;
            data_addr_ok = 1'b0;
            if (flushed) mem_valid = 1'b0;
            flush = ((i - 1) == flush_at);
            if (flush) flushed = 1'b1;
            data_data_ok = (i == data_lat);
            data_rdata   = data_data_ok ? rd : ~rd;
        end
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = ~rd; flush = 1'b0;
        idle_exp();
        if (flushed) begin
            mem_valid = 1'b0;
        end else begin
            exp_done = 1'b1;
            if (!is_store(op)) exp_rdata = ext(op, a, rd);
        end
        step();
        mem_valid = 1'b0;
        idle_exp();
    endtask

    task automatic run_mis(input logic [2:0] op, input logic [31:0] a,
                           input logic exp_l, input logic exp_s);
        saw_req = 1'b0;
        step();
        mem_valid = 1'b1; mem_op = op; addr = a; wdata = 32'h1234_5678;
        idle_exp();
        @(negedge clk);
        chk("mis_laddr_lit", laddr_err, exp_l);
        chk("mis_saddr_lit", saddr_err, exp_s);
        step();
        step();
        mem_valid = 1'b0;
        step();
        chk("mis_no_req", saw_req, 1'b0);
    endtask

    initial begin
        rst = 1'b1; mem_valid = 1'b0; mem_op = LB; addr = '0; wdata = '0; flush = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        idle_exp();
        exp_wr = 1'b0; exp_size = 2'd0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
        saw_req = 1'b0; snap_wdata = '0; snap_size = '0; snap_wr = 1'b0;
        @(negedge clk);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_req",   data_req, 1'b0);
        step();
        rst = 1'b0;

        // LW, addr_ok and data_ok together
        run_op(LW, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 0, -1);
        @(negedge clk);
        chk("lw_lit", rdata, 32'hDEAD_BEEF);

        // LB / LBU top byte, data_ok 3 cycles after addr_ok
        run_op(LB, 32'h0000_1003, 32'h0, 32'h8011_2233, 0, 3, -1);
        @(negedge clk);
        chk("lb_lit", rdata, 32'hFFFF_FF80);
        run_op(LBU, 32'h0000_1003, 32'h0, 32'h8011_2233, 0, 3, -1);
        @(negedge clk);
        chk("lbu_lit", rdata, 32'h0000_0080);

        // SH lane replication
        saw_req = 1'b0;
        run_op(SH, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 0, 1, -1);
        @(negedge clk);
        chk("sh_wdata_lit", snap_wdata, 32'hABCD_ABCD);
        chk("sh_size_lit",  snap_size,  2'd1);
        chk("sh_wr_lit",    snap_wr,    1'b1);
        chk("sh_rdata_keep", rdata, 32'h0000_0080);

        // More lane/extension patterns and slower slaves
        run_op(LH,  32'h0000_1002, 32'h0, 32'h8001_7FFF, 1, 0, -1);
        @(negedge clk);
        chk("lh_lit", rdata, 32'hFFFF_8001);
        run_op(LHU, 32'h0000_1000, 32'h0, 32'h1234_F00D, 2, 2, -1);
        run_op(LB,  32'h0000_1001, 32'h0, 32'h1122_7F44, 0, 1, -1);
        run_op(SB,  32'h0000_3001, 32'h1234_5678, 32'h0, 1, 1, -1);
        run_op(SW,  32'h0000_4000, 32'hCAFE_BABE, 32'h0, 2, 1, -1);

        // Misaligned ops never reach the bus
        run_mis(LW, 32'h0000_1001, 1'b1, 1'b0);
        run_mis(SH, 32'h0000_2001, 1'b0, 1'b1);
        run_mis(LH, 32'h0000_2003, 1'b1, 1'b0);
        run_mis(SW, 32'h0000_2002, 1'b0, 1'b1);

        // Flush during WAIT: no done, rdata unchanged
        run_op(LW, 32'h0000_1000, 32'h0, 32'h1111_1111, 0, 0, -1);
        saw_req = 1'b0;
        run_op(LW, 32'h0000_1004, 32'h0, 32'h9999_9999, 0, 3, 1);
        @(negedge clk);
        chk("flush_rdata_lit", rdata, 32'h1111_1111);

        // Flush in IDLE suppresses issue
        saw_req = 1'b0;
        step();
        mem_valid = 1'b1; mem_op = LW; addr = 32'h0000_6000; flush = 1'b1;
        idle_exp();
        step();
        mem_valid = 1'b0; flush = 1'b0;
        step();
        chk("flush_idle_no_req", saw_req, 1'b0);

`ifdef MEM_TIMEOUT_EN
        // Slave never accepts: watchdog fires after 8 cycles in REQ
        step();
        mem_valid = 1'b1; mem_op = LW; addr = 32'h0000_5000;
        idle_exp();
        exp_stall = 1'b1;
        exp_wr = 1'b0; exp_size = 2'd2; exp_addr = 32'h0000_5000; exp_wdata = 32'h0;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_req = 1'b1; exp_stall = 1'b1;
        end
        step();
        mem_valid = 1'b0;
        idle_exp();
        exp_bus_err = 1'b1;
        @(negedge clk);
        chk("timeout_bus_err_lit", bus_err, 1'b1);
        step();
        idle_exp();
`endif

        // Asynchronous reset in the middle of a transaction
        step();
        mem_valid = 1'b1; mem_op = LW; addr = 32'h0000_7000;
        idle_exp();
        exp_stall = 1'b1;
        exp_wr = 1'b0; exp_size = 2'd2; exp_addr = 32'h0000_7000; exp_wdata = 32'h0;
        step();
        exp_req = 1'b1;
        #2;
        rst = 1'b1; mem_valid = 1'b0;
        idle_exp();
        exp_rdata = 32'h0;
        @(negedge clk);
        chk("midreset_rdata_lit", rdata, 32'h0);
        step();
        rst = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
